drum_driver: RTL

DRUM_DRIVER -- requirements
Module: drum_driver

---
 rtl/drum_driver_pkg.sv | 30 +++
 rtl/drum_driver_tick_counter.sv | 26 ++
 rtl/drum_driver.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/drum_driver_pkg.sv
// Shared types for the drum driver: FSM state encoding, motor speed codes,
// tick counter width and the tick-count clamp helper.
package drum_driver_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        SOAK,
        AGIT_FWD,
        PAUSE_A,
        AGIT_REV,
        PAUSE_B,
        DRAIN,
        SPIN,
        BRAKE
    } state_t;

    localparam logic [1:0] SPEED_STOP    = 2'd0;
    localparam logic [1:0] SPEED_AGITATE = 2'd1;
    localparam logic [1:0] SPEED_MEDIUM  = 2'd2;
    localparam logic [1:0] SPEED_HIGH    = 2'd3;

    localparam int CNT_W = 16;

    // A zero-length phase still lasts one cycle.
    function automatic logic [CNT_W-1:0] ticks(input int n);
        return (n < 1) ? CNT_W'(1) : CNT_W'(n);
    endfunction

endpackage

// File: rtl/drum_driver_tick_counter.sv
// Loadable down-counter that stops at zero; o_done flags the last cycle.
// Ports: clock, reset (async high), i_load, i_value -> o_done.
module tick_counter
    import drum_driver_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (r_count != '0)
            r_count <= r_count - CNT_W'(1);
    end

    assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/drum_driver.sv
// Washing-machine drum driver: fill, soak, agitate, drain, spin, brake.
// Inputs: clock, reset (async high), lid, water_Intake, soak/wash/rinse/
// spin_Operation. Outputs (all registered): valve_Open, drain_Pump,
// door_Lock, motor_Enable, motor_Dir, motor_Speed[1:0].
// Build option: DRUM_DRIVER_SPIN_RAMP_EN ramps spin speed 1->2->3.
module drum_driver
    import drum_driver_pkg::*;
#(
    parameter int AGITATE_TICKS = 40,
    parameter int PAUSE_TICKS   = 10,
    parameter int DRAIN_TICKS   = 60,
    parameter int RAMP_TICKS    = 20,
    parameter int BRAKE_TICKS   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lid,
    input  logic       water_Intake,
    input  logic       soak_Operation,
    input  logic       wash_Operation,
    input  logic       rinse_Operation,
    input  logic       spin_Operation,
    output logic       valve_Open,
    output logic       drain_Pump,
    output logic       door_Lock,
    output logic       motor_Enable,
    output logic       motor_Dir,
    output logic [1:0] motor_Speed
);

    state_t           r_state;
    state_t           w_next;
    logic             w_wash;
    logic             w_load;
    logic             w_done;
    logic [CNT_W-1:0] w_ticks;

    logic       w_valve, w_pump, w_lock, w_en, w_dir;
    logic [1:0] w_speed;
    logic       r_valve, r_pump, r_lock, r_en, r_dir;
    logic [1:0] r_speed;
    logic [1:0] w_ramp;

    assign w_wash = wash_Operation | rinse_Operation;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // BRAKE is exempt from the lid override so it can still time out.
    always_comb begin
        w_next = r_state;
        if (lid && r_state != IDLE && r_state != BRAKE) begin
            w_next = BRAKE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!lid) begin
                        if (spin_Operation)    w_next = DRAIN;
                        else if (w_wash)       w_next = AGIT_FWD;
                        else if (water_Intake) w_next = FILL;
                        else if (soak_Operation) w_next = SOAK;
                    end
                end
                FILL:
                    if (!water_Intake) w_next = IDLE;
                SOAK: begin
                    if (spin_Operation)       w_next = DRAIN;
                    else if (w_wash)          w_next = AGIT_FWD;
                    else if (water_Intake)    w_next = FILL;
                    else if (!soak_Operation) w_next = IDLE;
                end
                AGIT_FWD:
                    if (!w_wash)     w_next = BRAKE;
                    else if (w_done) w_next = PAUSE_A;
                PAUSE_A:
                    if (!w_wash)     w_next = IDLE;
                    else if (w_done) w_next = AGIT_REV;
                AGIT_REV:
                    if (!w_wash)     w_next = BRAKE;
                    else if (w_done) w_next = PAUSE_B;
                PAUSE_B:
                    if (!w_wash)     w_next = IDLE;
                    else if (w_done) w_next = AGIT_FWD;
                DRAIN:
                    if (w_done) w_next = SPIN;
                SPIN:
                    if (!spin_Operation) w_next = BRAKE;
                BRAKE:
                    if (w_done) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // SPIN reloads its step timer; only the ramp build observes it.
    always_comb begin
        w_ticks = '0;
        unique case (w_next)
            AGIT_FWD, AGIT_REV: w_ticks = ticks(AGITATE_TICKS);
            PAUSE_A, PAUSE_B:   w_ticks = ticks(PAUSE_TICKS);
            DRAIN:              w_ticks = ticks(DRAIN_TICKS);
            SPIN:               w_ticks = ticks(RAMP_TICKS);
            BRAKE:              w_ticks = ticks(BRAKE_TICKS);
            default:            w_ticks = '0;
        endcase
    end

    assign w_load = (w_next != r_state)
                  || (r_state == SPIN && w_done);

    tick_counter u_tick (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_ticks),
        .o_done  (w_done)
    );

`ifdef DRUM_DRIVER_SPIN_RAMP_EN
    logic [1:0] r_ramp;

    always_comb begin
        w_ramp = SPEED_STOP;
        if (w_next == SPIN) begin
            if (r_state != SPIN)
                w_ramp = SPEED_AGITATE;
            else if (w_done && r_ramp != SPEED_HIGH)
                w_ramp = r_ramp + 2'd1;
            else
                w_ramp = r_ramp;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_ramp <= SPEED_STOP;
        else
            r_ramp <= w_ramp;
    end
`else
    assign w_ramp = SPEED_HIGH;
`endif

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        w_valve = 1'b0;
        w_pump  = 1'b0;
        w_en    = 1'b0;
        w_dir   = 1'b0;
        w_speed = SPEED_STOP;
        w_lock  = (w_next != IDLE) && (w_next != FILL);
        unique case (w_next)
            FILL:
                w_valve = water_Intake & ~lid;
            AGIT_FWD: begin
                w_en    = 1'b1;
                w_speed = SPEED_AGITATE;
            end
            AGIT_REV: begin
                w_en    = 1'b1;
                w_dir   = 1'b1;
                w_speed = SPEED_AGITATE;
            end
            DRAIN:
                w_pump = 1'b1;
            SPIN: begin
                w_pump  = 1'b1;
                w_en    = 1'b1;
                w_speed = w_ramp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valve <= 1'b0;
            r_pump  <= 1'b0;
            r_lock  <= 1'b0;
            r_en    <= 1'b0;
            r_dir   <= 1'b0;
            r_speed <= SPEED_STOP;
        end else begin
            r_valve <= w_valve;
            r_pump  <= w_pump;
            r_lock  <= w_lock;
            r_en    <= w_en;
            r_dir   <= w_dir;
            r_speed <= w_speed;
        end
    end

    assign valve_Open   = r_valve;
    assign drain_Pump   = r_pump;
    assign door_Lock    = r_lock;
    assign motor_Enable = r_en;
    assign motor_Dir    = r_dir;
    assign motor_Speed  = r_speed;

endmodule
